// File: rtl/glay_kernel_control.sv
// glay_kernel_control
// Kernel-level ap_ctrl_chain sequencer. Converts the host's level-based
// ap_start/ap_continue protocol into one valid/ready descriptor transfer to
// the compute unit, tracks CU completion, and reports run length and
// protocol errors.
//
// Ports:
//   ap_clk            kernel clock (rising edge)
//   ap_rst_n          asynchronous active-low reset
//   ap_start          host start level, held until ap_ready
//   ap_continue       host acknowledge of ap_done
//   descriptor_in     packed kernel arguments
//   ap_idle           kernel idle
//   ap_ready          one-cycle pulse: arguments consumed
//   ap_done           run complete, held until ap_continue
//   descriptor_valid  descriptor offered to CU
//   descriptor_ready  CU accepts descriptor
//   descriptor_out    latched descriptor
//   cu_done           CU completion pulse
//   busy_cycles       cycles spent in START+BUSY of last/current run
//   error_sticky      protocol violation seen since reset
module glay_kernel_control #(
    parameter int DESCRIPTOR_WIDTH = 576,
    parameter int COUNTER_WIDTH    = 32
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        ap_start,
    input  logic                        ap_continue,
    input  logic [DESCRIPTOR_WIDTH-1:0] descriptor_in,
    output logic                        ap_idle,
    output logic                        ap_ready,
    output logic                        ap_done,
    output logic                        descriptor_valid,
    input  logic                        descriptor_ready,
    output logic [DESCRIPTOR_WIDTH-1:0] descriptor_out,
    input  logic                        cu_done,
    output logic [COUNTER_WIDTH-1:0]    busy_cycles,
    output logic                        error_sticky
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
        return (&v) ? v : (v + CNT_ONE);
    endfunction

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state            <= IDLE;
            ap_idle          <= 1'b1;
            ap_ready         <= 1'b0;
            ap_done          <= 1'b0;
            descriptor_valid <= 1'b0;
            descriptor_out   <= '0;
            busy_cycles      <= '0;
            error_sticky     <= 1'b0;
        end else begin
            // A completion pulse is only meaningful while the CU is running;
            // anywhere else (including the acceptance cycle in START) it is
            // dropped and flagged.
            if (cu_done && (state != BUSY)) begin
                error_sticky <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (ap_start) begin
                        descriptor_out   <= descriptor_in;
                        descriptor_valid <= 1'b1;
                        ap_ready         <= 1'b1;
                        ap_idle          <= 1'b0;
                        busy_cycles      <= '0;
                        state            <= START;
                    end
                end

                START: begin
                    ap_ready    <= 1'b0;
                    busy_cycles <= sat_inc(busy_cycles);
                    if (descriptor_valid && descriptor_ready) begin
                        descriptor_valid <= 1'b0;
                        state            <= BUSY;
                    end
                end

                BUSY: begin
                    busy_cycles <= sat_inc(busy_cycles);
                    if (cu_done) begin
                        ap_done <= 1'b1;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    // busy_cycles is frozen here so the host can read the run length.
                    if (ap_continue) begin
                        ap_done <= 1'b0;
                        ap_idle <= 1'b1;
                        state   <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glay_kernel_control.sv
module tb_glay_kernel_control;

    localparam int DW = 576;
    localparam int CW = 32;

    logic          ap_clk;
    logic          ap_rst_n;
    logic          ap_start;
    logic          ap_continue;
    logic [DW-1:0] descriptor_in;
    logic          ap_idle;
    logic          ap_ready;
    logic          ap_done;
    logic          descriptor_valid;
    logic          descriptor_ready;
    logic [DW-1:0] descriptor_out;
    logic          cu_done;
    logic [CW-1:0] busy_cycles;
    logic          error_sticky;

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    logic          s_idle, s_ready, s_done, s_valid, s_err;
    logic [DW-1:0] s_desc;
    logic [3:0]    s_busy;

    glay_kernel_control #(.DESCRIPTOR_WIDTH(DW), .COUNTER_WIDTH(CW)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_continue(ap_continue), .descriptor_in(descriptor_in),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
        .descriptor_valid(descriptor_valid), .descriptor_ready(descriptor_ready),
        .descriptor_out(descriptor_out), .cu_done(cu_done),
        .busy_cycles(busy_cycles), .error_sticky(error_sticky)
    );

    glay_kernel_control #(.DESCRIPTOR_WIDTH(DW), .COUNTER_WIDTH(4)) dut_sat (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_continue(ap_continue), .descriptor_in(descriptor_in),
        .ap_idle(s_idle), .ap_ready(s_ready), .ap_done(s_done),
        .descriptor_valid(s_valid), .descriptor_ready(descriptor_ready),
        .descriptor_out(s_desc), .cu_done(cu_done),
        .busy_cycles(s_busy), .error_sticky(s_err)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0] P1, P2, P3, P4, P5;

    typedef struct {
        logic        start;
        logic        cont;
        logic        dready;
        logic        cu_done;
        logic [3:0]  exp_flags;   // {idle, ready, done, valid}
        int unsigned exp_busy;
        logic        chk_desc;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [3:0] flags();
        return {ap_idle, ap_ready, ap_done, descriptor_valid};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_desc(input string name, input logic [DW-1:0] exp);
        tests_run++;
        if (descriptor_out !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, descriptor_out, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after a clock edge with reset released.
    task automatic do_reset();
        ap_rst_n         = 1'b0;
        ap_start         = 1'b0;
        ap_continue      = 1'b0;
        descriptor_ready = 1'b0;
        cu_done          = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        P1 = {9{64'h0123_4567_89AB_CDEF}};
        P2 = {9{64'hFEDC_BA98_7654_3210}};
        P3 = {9{64'h5A5A_0F0F_3C3C_9696}};
        P4 = {9{64'hDEAD_BEEF_CAFE_F00D}};
        P5 = {9{64'h1111_2222_3333_4444}};
        descriptor_in = P1;

        // Basic run vectors: index = cycle number after reset release.
        for (int i = 0; i < 18; i++) begin
            tbl[i].start     = 1'b0;
            tbl[i].cont      = 1'b0;
            tbl[i].dready    = 1'b1;
            tbl[i].cu_done   = 1'b0;
            tbl[i].exp_flags = 4'b0000;
            tbl[i].exp_busy  = 0;
            tbl[i].chk_desc  = 1'b0;
        end
        tbl[0].start     = 1'b1;
        tbl[0].exp_flags = 4'b1000;
        tbl[1].exp_flags = 4'b0101;
        tbl[1].chk_desc  = 1'b1;
        for (int i = 2; i <= 10; i++) tbl[i].exp_busy = i - 1;
        tbl[10].cu_done = 1'b1;
        for (int i = 11; i <= 15; i++) begin
            tbl[i].exp_flags = 4'b0010;
            tbl[i].exp_busy  = 10;
        end
        tbl[15].cont = 1'b1;
        for (int i = 16; i <= 17; i++) begin
            tbl[i].exp_flags = 4'b1000;
            tbl[i].exp_busy  = 10;
        end

        // Reset state while reset is asserted
        ap_rst_n = 1'b0;
        ap_start = 1'b0; ap_continue = 1'b0; descriptor_ready = 1'b0; cu_done = 1'b0;
        #12;
        chk("reset_flags", {60'd0, flags()}, {60'd0, 4'b1000});
        chk("reset_busy", busy_cycles, 0);
        chk("reset_err", error_sticky, 0);
        tests_run++;
        if (descriptor_out !== '0) begin
            tests_failed++;
            $display("FAIL reset_desc: got %0h expected 0", descriptor_out);
        end

        // Basic run
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i > 0) step();
            chk($sformatf("basic_flags_c%0d", i), {60'd0, flags()}, {60'd0, tbl[i].exp_flags});
            chk($sformatf("basic_busy_c%0d", i), busy_cycles, 64'(tbl[i].exp_busy));
            if (tbl[i].chk_desc) chk_desc("basic_desc", P1);
            ap_start         = tbl[i].start;
            ap_continue      = tbl[i].cont;
            descriptor_ready = tbl[i].dready;
            cu_done          = tbl[i].cu_done;
        end

        // Backpressure with descriptor_in changing during the wait
        descriptor_in = P2; ap_start = 1'b1; descriptor_ready = 1'b0;
        step();
        chk("bp_first_flags", {60'd0, flags()}, {60'd0, 4'b0101});
        ap_start = 1'b0; descriptor_in = P3;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("bp_valid_k%0d", k), descriptor_valid, 1);
            chk_desc($sformatf("bp_desc_k%0d", k), P2);
            descriptor_ready = (k == 5);
            step();
        end
        chk("bp_after_flags", {60'd0, flags()}, {60'd0, 4'b0000});
        chk("bp_busy", busy_cycles, 6);
        descriptor_ready = 1'b0;
        cu_done = 1'b1;
        step();
        cu_done = 1'b0;
        chk("bp_done_flags", {60'd0, flags()}, {60'd0, 4'b0010});
        chk("bp_done_busy", busy_cycles, 7);

        // Held ap_done with ap_start held high
        ap_start = 1'b1; descriptor_in = P4;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("hold_flags_k%0d", k), {60'd0, flags()}, {60'd0, 4'b0010});
            chk($sformatf("hold_busy_k%0d", k), busy_cycles, 7);
        end
        ap_continue = 1'b1; ap_start = 1'b0;
        step();
        ap_continue = 1'b0;
        chk("hold_idle_flags", {60'd0, flags()}, {60'd0, 4'b1000});
        chk("hold_idle_busy", busy_cycles, 7);
        step();
        chk("hold_no_requeue", {60'd0, flags()}, {60'd0, 4'b1000});
        chk_desc("hold_desc_kept", P2);

        // Protocol error: cu_done in IDLE
        chk("err_clear_before", error_sticky, 0);
        cu_done = 1'b1;
        step();
        cu_done = 1'b0;
        chk("err_idle_flags", {60'd0, flags()}, {60'd0, 4'b1000});
        chk("err_idle_sticky", error_sticky, 1);
        step();
        chk("err_idle_flags2", {60'd0, flags()}, {60'd0, 4'b1000});

        // Protocol error: cu_done together with descriptor_ready in START
        do_reset();
        chk("err_reset_clear", error_sticky, 0);
        descriptor_in = P1; ap_start = 1'b1; descriptor_ready = 1'b1;
        step();
        chk("err2_start_flags", {60'd0, flags()}, {60'd0, 4'b0101});
        ap_start = 1'b0; cu_done = 1'b1;
        step();
        cu_done = 1'b0;
        chk("err2_busy_flags", {60'd0, flags()}, {60'd0, 4'b0000});
        chk("err2_sticky", error_sticky, 1);
        repeat (3) step();
        chk("err2_still_busy", {60'd0, flags()}, {60'd0, 4'b0000});
        cu_done = 1'b1;
        step();
        cu_done = 1'b0;
        chk("err2_done_flags", {60'd0, flags()}, {60'd0, 4'b0010});
        ap_continue = 1'b1;
        step();
        ap_continue = 1'b0;
        chk("err2_idle_flags", {60'd0, flags()}, {60'd0, 4'b1000});

        // Asynchronous reset while BUSY
        descriptor_in = P5; ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        repeat (4) step();
        chk("ar_busy_flags", {60'd0, flags()}, {60'd0, 4'b0000});
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        chk("ar_flags", {60'd0, flags()}, {60'd0, 4'b1000});
        chk("ar_busy", busy_cycles, 0);
        chk("ar_err", error_sticky, 0);
        chk_desc("ar_desc", '0);
        do_reset();
        descriptor_in = P3; ap_start = 1'b1; descriptor_ready = 1'b1;
        step();
        chk("ar_run_flags", {60'd0, flags()}, {60'd0, 4'b0101});
        chk_desc("ar_run_desc", P3);
        chk("ar_run_busy0", busy_cycles, 0);
        ap_start = 1'b0;
        step();
        cu_done = 1'b1;
        step();
        cu_done = 1'b0;
        chk("ar_run_done", {60'd0, flags()}, {60'd0, 4'b0010});
        chk("ar_run_busy", busy_cycles, 2);
        chk("ar_run_err", error_sticky, 0);
        ap_continue = 1'b1;
        step();
        ap_continue = 1'b0;
        chk("ar_run_idle", {60'd0, flags()}, {60'd0, 4'b1000});

        // Saturation: 30 cycles in START+BUSY
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        repeat (29) step();
        cu_done = 1'b1;
        step();
        cu_done = 1'b0;
        chk("sat_done_flags", {60'd0, flags()}, {60'd0, 4'b0010});
        chk("sat_wide_busy", busy_cycles, 30);
        chk("sat_narrow_busy", s_busy, 15);
        repeat (3) step();
        chk("sat_narrow_held", s_busy, 15);
        chk("sat_wide_held", busy_cycles, 30);
        ap_continue = 1'b1;
        step();
        ap_continue = 1'b0;
        chk("sat_idle", {60'd0, flags()}, {60'd0, 4'b1000});
        chk("sat_narrow_idle", s_busy, 15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
